// File: rtl/ula_wb_if.sv
// ula_wb_if -- bus bundle between the ALU stage, the writeback buffer and
// the register file.
//   upstream  : in_valid/in_ready handshake, resu, o_in/c_in/s_in/z_in,
//               op, dest, we_in, flag_en
//   writeback : out_valid/out_ready handshake, wb_data, wb_addr, wb_we
//   flags     : flags {O,C,S,Z}, cond -> cond_true
// slave is the buffer's view; master is the driver/consumer's view.
interface ula_wb_if #(
    parameter int bits = 16
);
    logic            in_valid;
    logic            in_ready;
    logic [bits-1:0] resu;
    logic            o_in;
    logic            c_in;
    logic            s_in;
    logic            z_in;
    logic [7:0]      op;
    logic [3:0]      dest;
    logic            we_in;
    logic            flag_en;
    logic            out_valid;
    logic            out_ready;
    logic [bits-1:0] wb_data;
    logic [3:0]      wb_addr;
    logic            wb_we;
    logic [3:0]      flags;
    logic [2:0]      cond;
    logic            cond_true;

    modport slave (
        input  in_valid, resu, o_in, c_in, s_in, z_in, op, dest, we_in,
               flag_en, out_ready, cond,
        output in_ready, out_valid, wb_data, wb_addr, wb_we, flags, cond_true
    );

    modport master (
        output in_valid, resu, o_in, c_in, s_in, z_in, op, dest, we_in,
               flag_en, out_ready, cond,
        input  in_ready, out_valid, wb_data, wb_addr, wb_we, flags, cond_true
    );
endinterface

// File: rtl/ula_wb.sv
// ula_wb -- 2-entry writeback buffer behind the ALU, plus the architectural
// flag register and branch-condition evaluation.
//   clk      : rising-edge clock
//   reset_n  : asynchronous active-low reset
//   bus      : ula_wb_if.slave (upstream handshake, writeback handshake,
//              flags and condition evaluation)
// Parameters: bits = datapath width, depth = buffer entries (only 2 works).
module ula_wb #(
    parameter int bits  = 16,
    parameter int depth = 2
) (
    input  logic     clk,
    input  logic     reset_n,
    ula_wb_if.slave  bus
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            wr_ptr_q;
    logic            rd_ptr_q;
    logic [bits-1:0] data_q [depth];
    logic [3:0]      addr_q [depth];
    logic            we_q   [depth];
    logic [3:0]      flags_q;

    logic accept;
    logic pop;
    logic flag_upd;
    logic unused_op;

    // Gating with reset_n keeps in_ready low while reset is held, yet high
    // from the first cycle after release since state is already EMPTY.
    assign bus.in_ready  = reset_n & (state_q != FULL);
    assign bus.out_valid = (state_q != EMPTY);

    assign accept = bus.in_valid & bus.in_ready;
    assign pop    = bus.out_valid & bus.out_ready;

    // Constant-format ops carry op[6]=1; only op[6]=0 formats touch flags.
    assign flag_upd  = accept & bus.flag_en & ~bus.op[6];
    assign unused_op = ^{bus.op[7], bus.op[5:0]};

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY: if (accept) state_d = ONE;
            ONE: begin
                if (accept && !pop)      state_d = FULL;
                else if (pop && !accept) state_d = EMPTY;
            end
            FULL:    if (pop) state_d = ONE;
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= EMPTY;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            flags_q  <= '0;
            for (int unsigned i = 0; i < depth; i++) begin
                data_q[i] <= '0;
                addr_q[i] <= '0;
                we_q[i]   <= 1'b0;
            end
        end else begin
            state_q <= state_d;
            if (accept) begin
                data_q[wr_ptr_q] <= bus.resu;
                addr_q[wr_ptr_q] <= bus.dest;
                we_q[wr_ptr_q]   <= bus.we_in;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            if (flag_upd) begin
                flags_q <= {bus.o_in, bus.c_in, bus.s_in, bus.z_in};
            end
        end
    end

    assign bus.wb_data = data_q[rd_ptr_q];
    assign bus.wb_addr = addr_q[rd_ptr_q];
    assign bus.wb_we   = we_q[rd_ptr_q];
    assign bus.flags   = flags_q;

    // Decoded from the registered flags only; no bypass of an in-flight update.
    always_comb begin
        bus.cond_true = 1'b0;
        unique case (bus.cond)
            3'b000:  bus.cond_true = 1'b1;
            3'b001:  bus.cond_true = flags_q[0];
            3'b010:  bus.cond_true = ~flags_q[0];
            3'b011:  bus.cond_true = flags_q[1];
            3'b100:  bus.cond_true = ~flags_q[1];
            3'b101:  bus.cond_true = flags_q[2];
            3'b110:  bus.cond_true = flags_q[3];
            default: bus.cond_true = 1'b0;
        endcase
    end
endmodule

// File: tb/tb_ula_wb.sv
// tb_ula_wb -- directed bench for ula_wb with a queue-based reference model
// that is compared against the DUT on every falling clock edge.
module tb_ula_wb;
    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    ula_wb_if #(.bits(16)) bus ();

    ula_wb #(.bits(16), .depth(2)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] d;
        logic [3:0]  a;
        logic        w;
    } ent_t;

    ent_t       mq[$];
    logic [3:0] mflags = 4'b0000;
    logic       m_acc;
    logic       m_pop;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic mcond(input logic [2:0] c, input logic [3:0] f);
        case (c)
            3'd0:    return 1'b1;
            3'd1:    return f[0];
            3'd2:    return !f[0];
            3'd3:    return f[1];
            3'd4:    return !f[1];
            3'd5:    return f[2];
            3'd6:    return f[3];
            default: return 1'b0;
        endcase
    endfunction

    // Reference model: FIFO as a queue, flags as a plain register.
    always @(negedge reset_n) begin
        mq.delete();
        mflags = 4'b0000;
    end

    always @(posedge clk) begin
        if (reset_n) begin
            m_acc = bus.in_valid && (mq.size() < 2);
            m_pop = (mq.size() > 0) && bus.out_ready;
            if (m_acc && bus.flag_en && (bus.op[7:6] == 2'b00 || bus.op[7:6] == 2'b10))
                mflags = {bus.o_in, bus.c_in, bus.s_in, bus.z_in};
            if (m_pop) void'(mq.pop_front());
            if (m_acc) mq.push_back('{d: bus.resu, a: bus.dest, w: bus.we_in});
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (!reset_n) begin
            chk("rst_in_ready",  bus.in_ready,  0);
            chk("rst_out_valid", bus.out_valid, 0);
            chk("rst_wb_data",   bus.wb_data,   0);
            chk("rst_wb_addr",   bus.wb_addr,   0);
            chk("rst_wb_we",     bus.wb_we,     0);
            chk("rst_flags",     bus.flags,     0);
        end else begin
            chk("in_ready",  bus.in_ready,  mq.size() < 2);
            chk("out_valid", bus.out_valid, mq.size() > 0);
            if (mq.size() > 0) begin
                chk("wb_data", bus.wb_data, mq[0].d);
                chk("wb_addr", bus.wb_addr, mq[0].a);
                chk("wb_we",   bus.wb_we,   mq[0].w);
            end
            chk("flags",     bus.flags,     mflags);
            chk("cond_true", bus.cond_true, mcond(bus.cond, mflags));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] d, input logic [3:0] a, input logic w);
        bus.in_valid = 1'b1;
        bus.resu     = d;
        bus.dest     = a;
        bus.we_in    = w;
    endtask

    task automatic set_flags_in(input logic [3:0] f);
        {bus.o_in, bus.c_in, bus.s_in, bus.z_in} = f;
    endtask

    logic [3:0] fvals [4];

    initial begin
        bus.in_valid  = 1'b0;
        bus.resu      = '0;
        bus.o_in      = 1'b0;
        bus.c_in      = 1'b0;
        bus.s_in      = 1'b0;
        bus.z_in      = 1'b0;
        bus.op        = 8'h00;
        bus.dest      = 4'h0;
        bus.we_in     = 1'b0;
        bus.flag_en   = 1'b0;
        bus.out_ready = 1'b0;
        bus.cond      = 3'b000;

        repeat (2) step();
        reset_n = 1'b1;
        #1;
        chk("rel_in_ready", bus.in_ready, 1);
        chk("rel_out_valid", bus.out_valid, 0);

        // Single entry flows through with one cycle of latency.
        push(16'h0005, 4'd3, 1'b1);
        bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        chk("s1_valid", bus.out_valid, 1);
        chk("s1_data",  bus.wb_data,   16'h0005);
        chk("s1_addr",  bus.wb_addr,   4'd3);
        step();
        chk("s1_drain", bus.out_valid, 0);

        // Fill to FULL, third offer refused, then drain in order.
        bus.out_ready = 1'b0;
        push(16'h1111, 4'd1, 1'b1);
        step();
        push(16'h2222, 4'd2, 1'b0);
        step();
        chk("s2_full_ready", bus.in_ready, 0);
        chk("s2_head",       bus.wb_data,  16'h1111);
        push(16'h3333, 4'd7, 1'b1);
        step();
        chk("s2_hold_head",  bus.wb_data,  16'h1111);
        chk("s2_hold_addr",  bus.wb_addr,  4'd1);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        chk("s2_second",     bus.wb_data,  16'h2222);
        chk("s2_second_we",  bus.wb_we,    0);
        step();
        chk("s2_empty",      bus.out_valid, 0);

        // Streaming in ONE: accept and pop together keep one entry.
        bus.out_ready = 1'b0;
        push(16'h0100, 4'd5, 1'b1);
        step();
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            push(16'h0100 + 16'(i), 4'(i), 1'b1);
            step();
            chk("s3_valid", bus.out_valid, 1);
            chk("s3_ready", bus.in_ready,  1);
            chk("s3_data",  bus.wb_data,   16'h0100 + 16'(i));
        end
        bus.in_valid = 1'b0;
        step();
        chk("s3_drain", bus.out_valid, 0);

        // Flags: update on accept, constant-format ops leave them alone.
        bus.flag_en = 1'b1;
        bus.op      = 8'h01;
        bus.cond    = 3'b001;
        set_flags_in(4'b0101);
        push(16'h0000, 4'd0, 1'b0);
        chk("s4_nobypass", bus.cond_true, 0);
        step();
        chk("s4_flags",    bus.flags,     4'b0101);
        chk("s4_cond_z",   bus.cond_true, 1);
        bus.op = 8'h41;
        set_flags_in(4'b1110);
        step();
        chk("s4_const_op", bus.flags,     4'b0101);
        bus.op = 8'hC3;
        step();
        chk("s4_const_op2", bus.flags,    4'b0101);
        bus.op      = 8'h00;
        bus.flag_en = 1'b0;
        step();
        chk("s4_no_en",    bus.flags,     4'b0101);
        bus.flag_en = 1'b1;
        bus.op      = 8'h81;
        step();
        chk("s4_fmt10",    bus.flags,     4'b1110);
        bus.in_valid = 1'b0;
        step();

        // Always/never conditions across several flag values.
        fvals[0] = 4'b0000;
        fvals[1] = 4'b1111;
        fvals[2] = 4'b0101;
        fvals[3] = 4'b1010;
        bus.op = 8'h00;
        for (int k = 0; k < 4; k++) begin
            set_flags_in(fvals[k]);
            push(16'h00AA, 4'd9, 1'b0);
            step();
            bus.in_valid = 1'b0;
            bus.cond = 3'b111;
            #1;
            chk("s5_never",  bus.cond_true, 0);
            bus.cond = 3'b000;
            #1;
            chk("s5_always", bus.cond_true, 1);
            for (int c = 1; c < 7; c++) begin
                bus.cond = 3'(c);
                step();
            end
        end
        bus.flag_en = 1'b0;
        step();

        // Asynchronous reset while FULL.
        bus.out_ready = 1'b0;
        bus.flag_en   = 1'b1;
        set_flags_in(4'b1011);
        push(16'hAAAA, 4'd4, 1'b1);
        step();
        push(16'hBBBB, 4'd6, 1'b1);
        step();
        bus.in_valid = 1'b0;
        bus.flag_en  = 1'b0;
        chk("s6_full",   bus.in_ready, 0);
        chk("s6_flags",  bus.flags,    4'b1011);
        #2;
        reset_n = 1'b0;
        #1;
        chk("s6_rst_valid", bus.out_valid, 0);
        chk("s6_rst_flags", bus.flags,     0);
        chk("s6_rst_ready", bus.in_ready,  0);
        chk("s6_rst_data",  bus.wb_data,   0);
        step();
        reset_n = 1'b1;
        #1;
        chk("s6_rel_ready", bus.in_ready,  1);
        chk("s6_rel_valid", bus.out_valid, 0);
        push(16'h0005, 4'd3, 1'b1);
        bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        chk("s6_data",  bus.wb_data, 16'h0005);
        chk("s6_addr",  bus.wb_addr, 4'd3);
        step();
        chk("s6_drain", bus.out_valid, 0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
